// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller driven by a private shadow of the EX/MEM/WB destinations.
// Define FWD_HAZARD_PERF_EN to add saturating stall and forward activity counters.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    en,
    input  logic                    id_valid,
    input  logic [NREAD*REG_AW-1:0] id_rs,
    input  logic [NREAD-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    flush,
    output logic                    stall,
    output logic [2*NREAD-1:0]      fwd_sel
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_fwd_cnt
`endif
);

    localparam logic [1:0]        SEL_RF    = 2'd0;
    localparam logic [1:0]        SEL_MEMWB = 2'd1;
    localparam logic [1:0]        SEL_EXMEM = 2'd2;
    localparam logic [REG_AW-1:0] REG_X0    = '0;

    logic              ex_valid, ex_wr, ex_ld;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_valid, mem_wr, mem_ld;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_wr;
    logic [REG_AW-1:0] wb_rd;

    logic              ex_writer, mem_writer, wb_writer;
    logic [NREAD-1:0]  ex_hit, mem_hit;
    logic              ex_bubble;
    logic [2*NREAD-1:0] fwd_next;

    // x0 is hardwired zero, so a slot targeting it never produces anything worth forwarding
    assign ex_writer  = ex_valid  & ex_wr  & (ex_rd  != REG_X0);
    assign mem_writer = mem_valid & mem_wr & (mem_rd != REG_X0);
    assign wb_writer  = wb_valid  & wb_wr  & (wb_rd  != REG_X0);

    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        for (int i = 0; i < NREAD; i++) begin
            ex_hit[i]  = id_rs_used[i] & ex_writer  & (id_rs[i*REG_AW +: REG_AW] == ex_rd);
            mem_hit[i] = id_rs_used[i] & mem_writer & (id_rs[i*REG_AW +: REG_AW] == mem_rd);
        end
    end

    // A load still in EX has no data yet; flush overrides because the consumer is being killed anyway
    assign stall     = en & ~flush & id_valid & ex_ld & (|ex_hit);
    assign ex_bubble = flush | stall | ~id_valid;

    always_comb begin
        fwd_next = '0;
        for (int i = 0; i < NREAD; i++) begin
            fwd_next[2*i +: 2] = SEL_RF;
            if (!ex_bubble) begin
                if (ex_hit[i]) begin
                    fwd_next[2*i +: 2] = SEL_EXMEM;
                end else if (mem_hit[i]) begin
                    fwd_next[2*i +: 2] = SEL_MEMWB;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_wr    <= 1'b0;
            mem_ld    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_wr     <= 1'b0;
            fwd_sel   <= '0;
        end else if (en) begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_wr     <= mem_wr;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_wr    <= ex_wr;
            mem_ld    <= ex_ld;
            if (ex_bubble) begin
                ex_valid <= 1'b0;
                ex_rd    <= '0;
                ex_wr    <= 1'b0;
                ex_ld    <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                ex_rd    <= id_rd;
                ex_wr    <= id_reg_write;
                ex_ld    <= id_mem_read;
            end
            fwd_sel <= fwd_next;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if ((|fwd_sel) && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

    // An EX/MEM forward always targets a non-load, and the WB slot trails MEM by one advance
    for (genvar g = 0; g < NREAD; g++) begin : g_sel_chk
        assert property (@(posedge clk) disable iff (!arst_n) fwd_sel[2*g +: 2] != 2'd3);
        assert property (@(posedge clk) disable iff (!arst_n)
                         (fwd_sel[2*g +: 2] == SEL_EXMEM) |-> !mem_ld);
    end

    assert property (@(posedge clk) disable iff (!arst_n)
                     $past(en) |-> (wb_writer == $past(mem_writer)));

endmodule
